// File: rtl/shift_sequencer_pkg.sv
// Shared encodings for the shift sequencer and its shifter datapath.
package shift_sequencer_pkg;

    localparam logic [1:0] OP_HOLD = 2'b00;
    localparam logic [1:0] OP_SHL  = 2'b01;
    localparam logic [1:0] OP_SHR  = 2'b10;
    localparam logic [1:0] OP_ROR  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/shift_sequencer_shifter.sv
// Combinational 4-bit mux-based shifter: hold, shift left/right, rotate right.
module shift_sequencer_shifter
    import shift_sequencer_pkg::*;
(
    input  logic [3:0] din,
    input  logic [1:0] sel,
    output logic [3:0] dout
);

    always_comb begin
        dout = din;
        unique case (sel)
            OP_HOLD: dout = din;
            OP_SHL:  dout = {din[2:0], 1'b0};
            OP_SHR:  dout = {1'b0, din[3:1]};
            OP_ROR:  dout = {din[0], din[3:1]};
            default: dout = din;
        endcase
    end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle controller applying one shifter step per clock for `count` cycles.
module shift_sequencer
    import shift_sequencer_pkg::*;
#(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [3:0]       data_in,
    input  logic [1:0]       op,
    input  logic [CNT_W-1:0] count,
    output logic [1:0]       sel,
    output logic [3:0]       result,
    output logic             shift_out,
    output logic             ready,
    output logic             busy,
    output logic             done
);

    state_t           state;
    state_t           next_state;
    logic [1:0]       op_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [3:0]       step_val;
    logic             step_bit;
    logic             load;
    logic             step_en;
    logic             last_step;

    shift_sequencer_shifter u_shifter (
        .din  (result),
        .sel  (sel),
        .dout (step_val)
    );

    // Bit leaving the register for the active select.
    always_comb begin
        step_bit = 1'b0;
        unique case (sel)
            OP_HOLD: step_bit = 1'b0;
            OP_SHL:  step_bit = result[3];
            OP_SHR:  step_bit = result[0];
            OP_ROR:  step_bit = result[0];
            default: step_bit = 1'b0;
        endcase
    end

    assign last_step = (cnt_reg <= CNT_W'(1));

    always_comb begin
        next_state = state;
        ready      = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        sel        = OP_HOLD;
        load       = 1'b0;
        step_en    = 1'b0;
        unique case (state)
            S_IDLE: begin
                ready = 1'b1;
                if (start && !abort) begin
                    load = 1'b1;
                    if (count != '0)
                        next_state = S_RUN;
                    else
                        next_state = S_DONE;
                end
            end
            S_RUN: begin
                busy    = 1'b1;
                sel     = op_reg;
                step_en = !abort;
                if (abort)
                    next_state = S_IDLE;
                else if (last_step)
                    next_state = S_DONE;
            end
            S_DONE: begin
                done       = 1'b1;
                next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= next_state;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result    <= 4'b0000;
            shift_out <= 1'b0;
            op_reg    <= OP_HOLD;
            cnt_reg   <= '0;
        end else if (load) begin
            result    <= data_in;
            shift_out <= 1'b0;
            op_reg    <= op;
            cnt_reg   <= count;
        end else if (step_en) begin
            result    <= step_val;
            shift_out <= step_bit;
            // Counter parks at 1 on the final step; it never wraps.
            if (!last_step)
                cnt_reg <= cnt_reg - CNT_W'(1);
        end
    end

endmodule
